datamem_dump_ctrl: RTL and testbench

DATAMEM_DUMP_CTRL -- requirements
Module: datamem_dump_ctrl

---
 rtl/datamem_dump_ctrl_if.sv | 39 +++
 rtl/datamem_dump_ctrl.sv | 124 ++++++++++++
 tb/tb_datamem_dump_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/datamem_dump_ctrl_if.sv
// datamem_dump_ctrl_if: CPU, data-memory, dump-request and transmit-stream signals of the dump controller
interface datamem_dump_ctrl_if #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 7
);
   logic               cpu_halted_i;
   logic               cpu_enable_mem_i;
   logic [NB_ADDR-1:0] cpu_addr_i;
   logic [NB_DATA-1:0] cpu_data_write_i;
   logic               cpu_mem_read_i;
   logic               cpu_mem_write_i;
   logic [NB_DATA-1:0] cpu_data_o;
   logic               dump_start_i;
   logic               dump_busy_o;
   logic               dump_done_o;
   logic [NB_DATA-1:0] tx_data_o;
   logic               tx_valid_o;
   logic               tx_ready_i;
   logic               mem_enable_o;
   logic               mem_read_o;
   logic               mem_write_o;
   logic [NB_ADDR-1:0] mem_addr_o;
   logic [NB_DATA-1:0] mem_data_write_o;
   logic [NB_DATA-1:0] mem_data_i;

   modport slave (
      input  cpu_halted_i, cpu_enable_mem_i, cpu_addr_i, cpu_data_write_i,
             cpu_mem_read_i, cpu_mem_write_i, dump_start_i, tx_ready_i, mem_data_i,
      output cpu_data_o, dump_busy_o, dump_done_o, tx_data_o, tx_valid_o,
             mem_enable_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_write_o
   );

   modport master (
      output cpu_halted_i, cpu_enable_mem_i, cpu_addr_i, cpu_data_write_i,
             cpu_mem_read_i, cpu_mem_write_i, dump_start_i, tx_ready_i, mem_data_i,
      input  cpu_data_o, dump_busy_o, dump_done_o, tx_data_o, tx_valid_o,
             mem_enable_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_write_o
   );
endinterface

// File: rtl/datamem_dump_ctrl.sv
// datamem_dump_ctrl: streams the whole data memory to a transmitter while the CPU is halted; DATAMEM_DUMP_CHECKSUM_EN appends an XOR checksum word
module datamem_dump_ctrl #(
   parameter int NB_DATA    = 32,
   parameter int NB_ADDR    = 7,
   parameter int N_ELEMENTS = 128
) (
   input logic                clock_i,
   input logic                reset_i,
   datamem_dump_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE,
      READ,
      LATCH,
      SEND,
`ifdef DATAMEM_DUMP_CHECKSUM_EN
      CSUM,
`endif
      DONE
   } state_t;

   localparam logic [NB_ADDR:0] LAST = (NB_ADDR+1)'(N_ELEMENTS - 1);

   state_t             state, next_state;
   logic [NB_ADDR:0]   cnt;
   logic [NB_DATA-1:0] tx_data;
   logic               last;
   logic               start_dump;
   logic               accept;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
   logic [NB_DATA-1:0] csum;
`endif

   assign last          = cnt == LAST;
   assign start_dump    = state == IDLE && bus.dump_start_i && bus.cpu_halted_i;
   assign accept        = state == SEND && bus.tx_ready_i;
   assign bus.tx_data_o = tx_data;

   // State register; reset abandons any dump in flight
   always_ff @(posedge clock_i) begin
      if (!reset_i) state <= IDLE;
      else          state <= next_state;
   end

   // Next state and outputs; the CPU owns the memory port only while idle
   always_comb begin
      next_state           = state;
      bus.mem_enable_o     = 1'b0;
      bus.mem_read_o       = 1'b0;
      bus.mem_write_o      = 1'b0;
      bus.mem_addr_o       = cnt[NB_ADDR-1:0];
      bus.mem_data_write_o = '0;
      bus.cpu_data_o       = '0;
      bus.dump_busy_o      = state != IDLE;
      bus.dump_done_o      = 1'b0;
      bus.tx_valid_o       = 1'b0;
      case (state)
         IDLE: begin
            bus.mem_enable_o     = bus.cpu_enable_mem_i;
            bus.mem_read_o       = bus.cpu_mem_read_i;
            bus.mem_write_o      = bus.cpu_mem_write_i;
            bus.mem_addr_o       = bus.cpu_addr_i;
            bus.mem_data_write_o = bus.cpu_data_write_i;
            bus.cpu_data_o       = bus.mem_data_i;
            next_state           = start_dump ? READ : IDLE;
         end
         READ: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_read_o   = 1'b1;
            next_state       = LATCH;
         end
         LATCH: next_state = SEND;
         SEND: begin
            bus.tx_valid_o = 1'b1;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
            if (bus.tx_ready_i) next_state = last ? CSUM : READ;
`else
            if (bus.tx_ready_i) next_state = last ? DONE : READ;
`endif
         end
`ifdef DATAMEM_DUMP_CHECKSUM_EN
         CSUM: begin
            bus.tx_valid_o = 1'b1;
            if (bus.tx_ready_i) next_state = DONE;
         end
`endif
         DONE: begin
            bus.dump_done_o = 1'b1;
            next_state      = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Word counter, transmit holding register and running checksum
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         cnt     <= '0;
         tx_data <= '0;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
         csum    <= '0;
`endif
      end else begin
         if (start_dump) begin
            cnt  <= '0;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
            csum <= '0;
`endif
         end
         if (state == LATCH) begin
            tx_data <= bus.mem_data_i;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
            csum    <= csum ^ bus.mem_data_i;
`endif
         end
         if (accept) begin
            cnt <= cnt + 1'b1;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
            if (last) tx_data <= csum;
`endif
         end
      end
   end
endmodule

// File: tb/tb_datamem_dump_ctrl.sv
// tb_datamem_dump_ctrl: directed checks of the memory dump controller against a registered-read memory model
module tb_datamem_dump_ctrl;
   localparam int N = 128;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
   localparam int NW = N + 1;
`else
   localparam int NW = N;
`endif

   logic clock_i = 1'b0;
   logic reset_i = 1'b0;
   int   n_cmp   = 0;
   int   n_err   = 0;
   logic [31:0] mem [N];

   datamem_dump_ctrl_if #(.NB_DATA(32), .NB_ADDR(7)) bus ();

   datamem_dump_ctrl #(.NB_DATA(32), .NB_ADDR(7), .N_ELEMENTS(N)) dut (
      .clock_i(clock_i),
      .reset_i(reset_i),
      .bus    (bus)
   );

   always #5 clock_i = ~clock_i;

   // Data memory with one-cycle registered read
   always @(posedge clock_i) begin
      if (bus.mem_enable_o && bus.mem_write_o) mem[bus.mem_addr_o] <= bus.mem_data_write_o;
      if (bus.mem_enable_o && bus.mem_read_o) bus.mem_data_i <= mem[bus.mem_addr_o];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cpu_store(input logic [6:0] a, input logic [31:0] d);
      bus.cpu_enable_mem_i = 1'b1;
      bus.cpu_mem_write_i  = 1'b1;
      bus.cpu_addr_i       = a;
      bus.cpu_data_write_i = d;
      @(posedge clock_i);
      #1;
      bus.cpu_enable_mem_i = 1'b0;
      bus.cpu_mem_write_i  = 1'b0;
   endtask

   task automatic cpu_load(input logic [6:0] a);
      bus.cpu_enable_mem_i = 1'b1;
      bus.cpu_mem_read_i   = 1'b1;
      bus.cpu_addr_i       = a;
      @(posedge clock_i);
      #1;
      bus.cpu_enable_mem_i = 1'b0;
      bus.cpu_mem_read_i   = 1'b0;
   endtask

   task automatic dump(input int stall_word, input int abort_word);
      int cyc = 0, k = 0, stall = 0, last_acc = 0, dones = 0;
      logic [31:0] x = '0, exp_w;
      bit fin = 1'b0;
      @(negedge clock_i);
      bus.cpu_halted_i = 1'b1;
      bus.dump_start_i = 1'b1;
      @(posedge clock_i);
      #1 bus.dump_start_i = 1'b0;
      while (!fin && cyc < 2000) begin
         @(negedge clock_i);
         cyc++;
         if (cyc == 4) begin
            bus.cpu_enable_mem_i = 1'b1;
            bus.cpu_mem_write_i  = 1'b1;
            bus.cpu_mem_read_i   = 1'b1;
            bus.cpu_addr_i       = 7'd3;
            bus.cpu_data_write_i = 32'hDEADBEEF;
         end
         if (cyc >= 5 && cyc <= 8) begin
            check("lock_mem_write", 32'(bus.mem_write_o), 0);
            check("lock_cpu_data", bus.cpu_data_o, 0);
         end
         if (cyc == 9) begin
            bus.cpu_enable_mem_i = 1'b0;
            bus.cpu_mem_write_i  = 1'b0;
            bus.cpu_mem_read_i   = 1'b0;
         end
         if (cyc == 30) bus.cpu_halted_i = 1'b0;
         if (cyc == 45) bus.cpu_halted_i = 1'b1;
         if (cyc == 50) bus.dump_start_i = 1'b1;
         if (cyc == 51) bus.dump_start_i = 1'b0;
         if (bus.dump_done_o) begin
            dones++;
            check("done_cycle", cyc, last_acc + 1);
            @(negedge clock_i);
            check("busy_after_done", 32'(bus.dump_busy_o), 0);
            check("done_single", 32'(bus.dump_done_o), 0);
            fin = 1'b1;
         end else if (bus.tx_valid_o) begin
            if (k == abort_word) begin
               reset_i = 1'b0;
               @(negedge clock_i);
               reset_i = 1'b1;
               check("abort_busy", 32'(bus.dump_busy_o), 0);
               check("abort_valid", 32'(bus.tx_valid_o), 0);
               check("abort_done", 32'(bus.dump_done_o), 0);
               check("abort_tx_data", bus.tx_data_o, 0);
               repeat (5) begin
                  @(negedge clock_i);
                  check("abort_quiet", {bus.dump_busy_o, bus.tx_valid_o, bus.dump_done_o}, 0);
               end
               fin = 1'b1;
            end else if (k == stall_word && stall < 10) begin
               bus.tx_ready_i = 1'b0;
               check("stall_data", bus.tx_data_o, k + 1);
               stall++;
            end else begin
               bus.tx_ready_i = 1'b1;
               exp_w = (k == N) ? x : k + 1;
               check("word_data", bus.tx_data_o, exp_w);
               check("word_cycle", cyc, (k == N) ? last_acc + 1 :
                     3 * k + 3 + ((stall_word >= 0 && k >= stall_word) ? 10 : 0));
               x ^= exp_w;
               last_acc = cyc;
               k++;
            end
         end
      end
      if (!fin) check("dump_timeout", 1, 0);
      if (abort_word < 0) begin
         check("word_count", k, NW);
         check("done_count", dones, 1);
      end
      bus.tx_ready_i = 1'b1;
   endtask

   initial begin
      bus.cpu_halted_i     = 1'b0;
      bus.cpu_enable_mem_i = 1'b0;
      bus.cpu_addr_i       = '0;
      bus.cpu_data_write_i = '0;
      bus.cpu_mem_read_i   = 1'b0;
      bus.cpu_mem_write_i  = 1'b0;
      bus.dump_start_i     = 1'b0;
      bus.tx_ready_i       = 1'b1;
      repeat (2) @(posedge clock_i);
      #1;
      check("rst_busy", 32'(bus.dump_busy_o), 0);
      check("rst_valid", 32'(bus.tx_valid_o), 0);
      check("rst_done", 32'(bus.dump_done_o), 0);
      check("rst_tx_data", bus.tx_data_o, 0);
      reset_i = 1'b1;
      for (int i = 0; i < N; i++) cpu_store(7'(i), 32'(i + 1));
      cpu_load(7'd5);
      check("cpu_load", bus.cpu_data_o, 32'd6);
      bus.dump_start_i = 1'b1;
      @(posedge clock_i);
      #1 bus.dump_start_i = 1'b0;
      repeat (4) begin
         @(negedge clock_i);
         check("nohalt_busy", 32'(bus.dump_busy_o), 0);
         check("nohalt_valid", 32'(bus.tx_valid_o), 0);
      end
      @(posedge clock_i);
      #1;
      bus.cpu_enable_mem_i = 1'b1;
      bus.cpu_mem_write_i  = 1'b1;
      bus.cpu_addr_i       = 7'd10;
      bus.cpu_data_write_i = 32'hA5A5_0011;
      @(negedge clock_i);
      check("pass_write", 32'(bus.mem_write_o), 1);
      check("pass_addr", 32'(bus.mem_addr_o), 10);
      check("pass_wdata", bus.mem_data_write_o, 32'hA5A5_0011);
      @(posedge clock_i);
      #1;
      bus.cpu_enable_mem_i = 1'b0;
      bus.cpu_mem_write_i  = 1'b0;
      check("store_mem", mem[10], 32'hA5A5_0011);
      cpu_load(7'd10);
      check("load_back", bus.cpu_data_o, 32'hA5A5_0011);
      cpu_store(7'd10, 32'd11);
      dump(5, -1);
      check("word3_intact", mem[3], 32'd4);
      dump(-1, 40);
      dump(-1, -1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
